sccb_responder: RTL and testbench
=================================

# sccb_responder

Synchronous SCCB target (responder) that sits on the far end of the SIOC/SIOD camera bus and emulates an Omnivision-style register file. It decodes 3-phase writes, 2-phase address-set writes and 2-phase reads from the SCCB master, and returns register data on reads. It also reports every completed register write through a one-cycle strobe, for camera bring-up on the FPGA and for closed-loop simulation of the IIC-to-SCCB path.

## Interface
- DEVICE_ID, 7'h21: 7-bit target ID; write address byte 8'h42, read address byte 8'h43.
- RESET_VAL, 8'h00: reset value loaded into all 256 registers.
- clk  input  1  system clock; must run at ≥10× the SIOC frequency.
- rst  input  1  synchronous, active-high reset.
- SIOC  input  1  SCCB clock from the master, asynchronous to clk.
- SIOD  inout  1  SCCB data. The block only drives 0 or releases to 1'bz; the external pull-up supplies 1.
- reg_wr  output  1  one-cycle pulse when a register write commits.
- reg_addr  output  8  sub-address of the committed write; held until the next write.
- reg_wdata  output  8  data of the committed write; held until the next write.
- busy  output  1  high from START detect until STOP detect.

## Operation
- SIOC and SIOD each pass through a 2-FF synchronizer, then a 1-FF history stage for edge detection.
- START: synced SIOD falls while synced SIOC is high. STOP: synced SIOD rises while synced SIOC is high.
- Bits are sampled MSB-first on a synced SIOC rising edge. Output changes are applied on a synced SIOC falling edge.
- Internal state: 256×8 register array, 8-bit sub-address pointer, 4-bit bit counter, 8-bit shift register.
- FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NAK, IGNORE.
- IDLE → ID on START.
- ID: shift in 8 bits.
  - Bits[7:1] == DEVICE_ID → ID_ACK.
  - Otherwise → IGNORE, with SIOD never driven.
- ID_ACK: after the 9th clock, → SUB if bit0 = 0, or → RDATA if bit0 = 1.
  - Entering RDATA loads the shift register with regs[pointer].
- SUB: shift in 8 bits → SUB_ACK. At the 8th rising edge the pointer is loaded with the received byte.
- SUB_ACK → WDATA.
- WDATA: shift in 8 bits → WDATA_ACK.
  - At the 8th rising edge: regs[pointer] is written, reg_wr pulses, and reg_addr/reg_wdata update.
- WDATA_ACK → IGNORE. There is no auto-increment, so further bytes are neither written nor acknowledged.
- STOP after SUB_ACK (2-phase write) leaves the pointer set for a subsequent read.
- RDATA: drive SIOD = 0 for each 0 bit and release it for each 1 bit; → RDATA_NAK after 8 bits.
- RDATA_NAK: release SIOD and ignore the master's NA bit → IGNORE. The pointer does not increment.
- START in any state → ID (repeated start); the pointer is kept.
- STOP in any state → IDLE, SIOD released, busy = 0.
- Reset values:
  - FSM = IDLE, SIOD released, busy = 0, reg_wr = 0, reg_addr = 0, reg_wdata = 0, pointer = 0.
  - All registers = RESET_VAL.
- rst mid-transfer aborts immediately with these same values. The partially received byte is discarded and no write commits.

## Timing
- Synchronizer latency: 3 clk from a pin edge to the detected edge.
- SIOD drive changes are applied 1 clk after the detected SIOC fall, i.e. 4 clk after the pin fall.
- SIOD is released 1 clk after the detected SIOC fall that ends an ACK or read bit.
- reg_wr asserts 1 clk after the detected 8th rising edge of WDATA and lasts exactly 1 clk.
- The register array is updated in the same cycle reg_wr asserts. A read started on the next transaction returns the new value.
- A simultaneous START/STOP and SIOC edge cannot occur, because SIOC is high by definition. A START or STOP takes priority over bit processing in the same cycle.

## Configuration
- SCCB_RESP_ACK_EN defined: the block drives SIOD = 0 during the 9th bit of ID_ACK, SUB_ACK and WDATA_ACK. This is required for I2C masters that check ACK.
- SCCB_RESP_ACK_EN undefined: SIOD is released during every 9th bit (SCCB "don't-care"). The bus then reads 1 via the pull-up, and FSM sequencing is otherwise identical.

## Test plan
- Reset, then 2-phase write of sub-address 0x0A followed by a read from 0x43 → returns 8'h00. With ACK_EN, each 9th bit of the write phases is 0.
- 3-phase write 0x42, 0x12, 0x80 → reg_wr is a 1-clk pulse with reg_addr = 0x12 and reg_wdata = 0x80. A subsequent read of 0x12 returns 0x80.
- Write to ID byte 0x60 → SIOD is never driven, reg_wr stays 0, and busy goes 1→0 on STOP.
- 3-phase write followed by a 4th byte 0x55 → the 4th byte is not acknowledged, and regs[sub+1] is unchanged.
- Repeated START after the sub-address byte (0x42, 0x3C, Sr, 0x43) → returns regs[0x3C]; no write is committed.
- rst asserted in the middle of the WDATA byte → SIOD is released next cycle, reg_wr stays 0, and the target register holds its old value.

Source files
------------

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB target emulating an Omnivision-style 256x8 register file.
// Decodes 3-phase writes, 2-phase sub-address writes and 2-phase reads on SIOC/SIOD.
//
// Parameters:
//   DEVICE_ID  7-bit target ID (write byte {ID,0}, read byte {ID,1})
//   RESET_VAL  value loaded into every register on reset
// Ports:
//   clk        system clock, at least 10x the SIOC frequency
//   rst        synchronous active-high reset
//   SIOC       SCCB clock from the master (asynchronous to clk)
//   SIOD       SCCB data; only ever pulled to 0 or released to 'z'
//   reg_wr     one-cycle pulse per committed register write
//   reg_addr   sub-address of the last committed write
//   reg_wdata  data of the last committed write
//   busy       high between a detected START and a detected STOP
// Build option:
//   SCCB_RESP_ACK_EN  when defined, the 9th bit of each accepted write-phase
//                     byte is actively driven low (I2C-style ACK); otherwise
//                     it is left to the pull-up (SCCB don't-care bit).

module sccb_responder #(
    parameter logic [6:0] DEVICE_ID = 7'h21,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SIOC,
    inout  wire        SIOD,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       busy
);

`ifdef SCCB_RESP_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_NAK,
        S_IGNORE
    } state_t;

    // ---------------------------------------------------------------
    // Pin synchronizers and edge history
    // ---------------------------------------------------------------
    logic [1:0] sioc_sync_q;
    logic [1:0] siod_sync_q;
    logic       sioc_hist_q;
    logic       siod_hist_q;

    // Reset to 1 so an idle (pulled-up) bus is not mistaken for a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync_q <= 2'b11;
            siod_sync_q <= 2'b11;
            sioc_hist_q <= 1'b1;
            siod_hist_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[0], SIOC};
            siod_sync_q <= {siod_sync_q[0], SIOD};
            sioc_hist_q <= sioc_sync_q[1];
            siod_hist_q <= siod_sync_q[1];
        end
    end

    logic sioc_s;
    logic siod_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign sioc_s    = sioc_sync_q[1];
    assign siod_s    = siod_sync_q[1];
    assign scl_rise  = sioc_s & ~sioc_hist_q;
    assign scl_fall  = ~sioc_s & sioc_hist_q;
    assign start_det = sioc_s & sioc_hist_q & ~siod_s & siod_hist_q;
    assign stop_det  = sioc_s & sioc_hist_q & siod_s & ~siod_hist_q;

    // ---------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  regs_q [256];
    logic [7:0]  byte_in;
    logic [7:0]  rd_word;

    // Byte as it stands once the bit on the current rising edge is shifted in.
    assign byte_in = {shift_q[6:0], siod_s};
    assign rd_word = regs_q[ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            ptr_q   <= 8'h00;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Register file; written on the same edge that raises reg_wr.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (wr_d) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // cnt counts SIOC rising edges within a 9-bit frame: the data byte
    // ends at 8, the 9th (ACK/NA) rise takes it to 9, and the fall that
    // follows closes the frame.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (start_det) begin
            state_d = S_ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    oe_d = 1'b0;
                end

                S_ID: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (byte_in[7:1] == DEVICE_ID) begin
                                state_d = S_ID_ACK;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end

                S_SUB: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d   = byte_in;
                            state_d = S_SUB_ACK;
                        end
                    end
                end

                S_WDATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            wr_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = byte_in;
                            state_d = S_WDATA_ACK;
                        end
                    end
                end

                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (scl_rise) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d = ACK_DRIVE;
                        end else if (cnt_q == 4'd9) begin
                            cnt_d = 4'd0;
                            oe_d  = 1'b0;
                            if (state_q == S_ID_ACK) begin
                                // R/W bit is still in shift_q[0] from the ID byte.
                                if (shift_q[0]) begin
                                    state_d = S_RDATA;
                                    shift_d = rd_word;
                                    oe_d    = ~rd_word[7];
                                end else begin
                                    state_d = S_SUB;
                                end
                            end else if (state_q == S_SUB_ACK) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d   = cnt_q + 4'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = S_RDATA_NAK;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d = ~shift_q[7];
                        end
                    end
                end

                S_RDATA_NAK: begin
                    oe_d = 1'b0;
                    if (scl_rise) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd9) begin
                            cnt_d   = 4'd0;
                            state_d = S_IGNORE;
                        end
                    end
                end

                S_IGNORE: begin
                    oe_d = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign SIOD      = oe_q ? 1'b0 : 1'bz;
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bus-level master driving sccb_responder with directed
// and random SCCB transactions, checked against a register-file model.

module tb_sccb_responder;

`ifdef SCCB_RESP_ACK_EN
    localparam logic ACKV = 1'b0;
`else
    localparam logic ACKV = 1'b1;
`endif

    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sioc = 1'b1;
    logic       m_low = 1'b0;
    wire        siod;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;

    pullup (siod);
    assign siod = m_low ? 1'b0 : 1'bz;

    sccb_responder #(
        .DEVICE_ID(7'h21),
        .RESET_VAL(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SIOC     (sioc),
        .SIOD     (siod),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_exp[$];
    logic [7:0] rd_exp[$];
    logic [7:0] rd_obs[$];

    // Reference register file
    logic [7:0] mregs [256];
    logic [7:0] mptr;

    logic nodrive_en = 1'b0;
    int   nodrive_viol = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: commits and read bytes as they appear
    initial begin
        wr_t        w;
        logic [7:0] e;
        logic [7:0] o;
        forever begin
            @(negedge clk);
            if (reg_wr === 1'b1) begin
                checks++;
                if (wr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL reg_wr_unexpected: got addr=%02h data=%02h expected no write",
                             reg_addr, reg_wdata);
                end else begin
                    w = wr_exp.pop_front();
                    if (reg_addr !== w.a || reg_wdata !== w.d) begin
                        errors++;
                        $display("FAIL reg_wr: got addr=%02h data=%02h expected addr=%02h data=%02h",
                                 reg_addr, reg_wdata, w.a, w.d);
                    end
                end
            end
            while (rd_obs.size() > 0) begin
                o = rd_obs.pop_front();
                checks++;
                if (rd_exp.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: got %02h expected no read", o);
                end else begin
                    e = rd_exp.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL read_data: got %02h expected %02h", o, e);
                    end
                end
            end
            if (nodrive_en && siod === 1'b0 && !m_low) begin
                nodrive_viol++;
            end
        end
    end

    // ---------------- bus master primitives ----------------
    task automatic m_start();
        m_low = 1'b0;
        #Q sioc = 1'b1;
        #Q m_low = 1'b1;
        #Q sioc = 1'b0;
        #Q;
    endtask

    task automatic m_stop();
        m_low = 1'b1;
        #Q sioc = 1'b1;
        #Q m_low = 1'b0;
        #Q;
        #Q;
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        m_low = ~b;
        #Q sioc = 1'b1;
        #Q s = siod;
        #Q sioc = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic [7:0] t;
        logic       s;
        t = d;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(t[7], s);
            t = {t[6:0], 1'b0};
        end
        xfer_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(1'b1, s);
            d = {d[6:0], s};
        end
        xfer_bit(1'b1, s);
    endtask

    // ---------------- transactions + model ----------------
    task automatic t_write2(input logic [7:0] sub);
        logic a;
        mptr = sub;
        m_start();
        send_byte(8'h42, a);
        chk("w2_id_ack", int'(a), int'(ACKV));
        send_byte(sub, a);
        chk("w2_sub_ack", int'(a), int'(ACKV));
        m_stop();
    endtask

    task automatic t_write3(input logic [7:0] sub, input logic [7:0] data,
                            input logic extra_en, input logic [7:0] extra);
        logic a;
        wr_exp.push_back('{a: sub, d: data});
        mregs[sub] = data;
        mptr = sub;
        m_start();
        send_byte(8'h42, a);
        chk("w3_id_ack", int'(a), int'(ACKV));
        send_byte(sub, a);
        chk("w3_sub_ack", int'(a), int'(ACKV));
        send_byte(data, a);
        chk("w3_data_ack", int'(a), int'(ACKV));
        if (extra_en) begin
            send_byte(extra, a);
            chk("extra_byte_nak", int'(a), 1);
        end
        m_stop();
    endtask

    task automatic t_read();
        logic [7:0] d;
        logic       a;
        rd_exp.push_back(mregs[mptr]);
        m_start();
        send_byte(8'h43, a);
        chk("rd_id_ack", int'(a), int'(ACKV));
        recv_byte(d);
        rd_obs.push_back(d);
        m_stop();
    endtask

    task automatic t_rstart_read(input logic [7:0] sub);
        logic [7:0] d;
        logic       a;
        mptr = sub;
        rd_exp.push_back(mregs[sub]);
        m_start();
        send_byte(8'h42, a);
        chk("sr_id_ack", int'(a), int'(ACKV));
        send_byte(sub, a);
        chk("sr_sub_ack", int'(a), int'(ACKV));
        m_start();
        send_byte(8'h43, a);
        chk("sr_rd_ack", int'(a), int'(ACKV));
        recv_byte(d);
        rd_obs.push_back(d);
        m_stop();
    endtask

    task automatic t_badid(input logic [7:0] id);
        logic a;
        nodrive_viol = 0;
        nodrive_en = 1'b1;
        m_start();
        send_byte(id, a);
        chk("badid_ack", int'(a), 1);
        chk("badid_busy", int'(busy), 1);
        send_byte(8'(id + 8'd3), a);
        chk("badid_byte2_ack", int'(a), 1);
        m_stop();
        repeat (10) @(posedge clk);
        #1;
        nodrive_en = 1'b0;
        chk("badid_busy_after_stop", int'(busy), 0);
        chk("badid_siod_driven", nodrive_viol, 0);
    endtask

    task automatic t_reset_mid_wdata(input logic [7:0] sub, input logic [7:0] data);
        logic a;
        logic s;
        logic [7:0] t;
        m_start();
        send_byte(8'h42, a);
        chk("rst_id_ack", int'(a), int'(ACKV));
        send_byte(sub, a);
        chk("rst_sub_ack", int'(a), int'(ACKV));
        t = data;
        for (int i = 0; i < 4; i++) begin
            xfer_bit(t[7], s);
            t = {t[6:0], 1'b0};
        end
        m_low = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        mptr = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_siod_released", int'(siod), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_reg_addr", int'(reg_addr), 0);
        chk("rst_reg_wdata", int'(reg_wdata), 0);
        sioc = 1'b1;
        #(4 * Q);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [7:0] sub;
        logic [7:0] dat;
        logic [7:0] id;
        int         op;
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        mptr = 8'h00;

        repeat (4) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_reg_wr", int'(reg_wr), 0);
        chk("reset_reg_addr", int'(reg_addr), 0);
        chk("reset_reg_wdata", int'(reg_wdata), 0);
        chk("reset_siod", int'(siod), 1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_busy", int'(busy), 0);

        t_write2(8'h0A);
        t_read();
        t_write3(8'h12, 8'h80, 1'b0, 8'h00);
        t_read();
        t_badid(8'h60);
        t_write3(8'h20, 8'h5A, 1'b1, 8'h55);
        t_write2(8'h21);
        t_read();
        t_rstart_read(8'h12);
        t_reset_mid_wdata(8'h77, 8'hA5);
        t_write2(8'h77);
        t_read();

        for (int n = 0; n < 30; n++) begin
            op  = int'($urandom_range(0, 5));
            sub = 8'($urandom_range(0, 15));
            dat = 8'($urandom);
            case (op)
                0, 1: t_write3(sub, dat, 1'b0, 8'h00);
                2: begin
                    t_write2(sub);
                    t_read();
                end
                3: t_rstart_read(sub);
                4: begin
                    do id = 8'($urandom); while (id[7:1] == 7'h21);
                    t_badid(id);
                end
                default: t_write3(sub, dat, 1'b1, 8'($urandom));
            endcase
        end

        repeat (20) @(posedge clk);
        #1;
        chk("pending_writes", wr_exp.size(), 0);
        chk("pending_reads", rd_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
